// File: rtl/desentrelacar_placar_serial.sv
// desentrelacar_placar_serial
// Serial receiver for the packed score word. The word arrives LSB first.
// Bit 2k of the word is n1[k] and bit 2k+1 is n2[k]. When a frame is
// complete, n1/n2 are loaded together and pronto pulses for one cycle.
//
// Optional build macro: PARIDADE_PLACAR_EN
//   When defined, each frame carries one extra even-parity bit after the
//   data bits. A bad frame pulses erro_paridade and leaves n1/n2 alone.
//   When undefined, the frame is data only and erro_paridade is tied low.
//
// state     | meaning
// ----------+---------------------------------------------------------
// OCIOSO    | idle, waiting for inicio; serial bits are ignored
// RECEBENDO | collecting frame bits; inicio restarts the frame
// CONCLUIDO | one cycle: publish n1/n2 (or flag parity error), then idle

module desentrelacar_placar_serial #(
  parameter int LARGURA_N = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 inicio,
  input  logic                 entrada_bit,
  input  logic                 entrada_valida,
  output logic [LARGURA_N-1:0] n1,
  output logic [LARGURA_N-1:0] n2,
  output logic                 pronto,
  output logic                 ocupado,
  output logic                 erro_paridade
);

`ifdef PARIDADE_PLACAR_EN
  localparam int NBITS = 2 * LARGURA_N + 1;
`else
  localparam int NBITS = 2 * LARGURA_N;
`endif
  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    RECEBENDO = 2'd1,
    CONCLUIDO = 2'd2
  } estado_t;

  estado_t                estado_q, estado_d;
  logic [CW-1:0]          contador_q, contador_d;
  logic [LARGURA_N-1:0]   a_q, a_d;
  logic [LARGURA_N-1:0]   b_q, b_d;
  logic [LARGURA_N-1:0]   n1_q, n1_d;
  logic [LARGURA_N-1:0]   n2_q, n2_d;
  logic                   pronto_q, pronto_d;
`ifdef PARIDADE_PLACAR_EN
  // Running XOR of every bit of the frame, parity bit included.
  logic                   par_q, par_d;
  logic                   erro_q, erro_d;
`endif

  // State register and datapath registers; reset returns everything to idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q   <= OCIOSO;
      contador_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      n1_q       <= '0;
      n2_q       <= '0;
      pronto_q   <= 1'b0;
`ifdef PARIDADE_PLACAR_EN
      par_q      <= 1'b0;
      erro_q     <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
      a_q        <= a_d;
      b_q        <= b_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      pronto_q   <= pronto_d;
`ifdef PARIDADE_PLACAR_EN
      par_q      <= par_d;
      erro_q     <= erro_d;
`endif
    end
  end

  // Next-state logic: frame start/abort, bit steering, and publication.
  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    a_d        = a_q;
    b_d        = b_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    pronto_d   = 1'b0;
`ifdef PARIDADE_PLACAR_EN
    par_d      = par_q;
    erro_d     = 1'b0;
`endif

    unique case (estado_q)
      OCIOSO: begin
        if (inicio) begin
          estado_d   = RECEBENDO;
          contador_d = '0;
          a_d        = '0;
          b_d        = '0;
`ifdef PARIDADE_PLACAR_EN
          par_d      = 1'b0;
`endif
        end
      end

      RECEBENDO: begin
        if (inicio) begin
          // Restart wins over a bit arriving in the same cycle.
          contador_d = '0;
          a_d        = '0;
          b_d        = '0;
`ifdef PARIDADE_PLACAR_EN
          par_d      = 1'b0;
`endif
        end else if (entrada_valida) begin
          for (int k = 0; k < LARGURA_N; k++) begin
            if (contador_q == CW'(2 * k)) begin
              a_d[k] = entrada_bit;
            end
            if (contador_q == CW'(2 * k + 1)) begin
              b_d[k] = entrada_bit;
            end
          end
`ifdef PARIDADE_PLACAR_EN
          par_d = par_q ^ entrada_bit;
`endif
          if (contador_q == ULTIMO) begin
            estado_d   = CONCLUIDO;
            contador_d = '0;
          end else begin
            contador_d = contador_q + CW'(1);
          end
        end
      end

      CONCLUIDO: begin
        estado_d = OCIOSO;
`ifdef PARIDADE_PLACAR_EN
        if (!par_q) begin
          n1_d     = a_q;
          n2_d     = b_q;
          pronto_d = 1'b1;
        end else begin
          erro_d   = 1'b1;
        end
`else
        n1_d     = a_q;
        n2_d     = b_q;
        pronto_d = 1'b1;
`endif
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  assign n1      = n1_q;
  assign n2      = n2_q;
  assign pronto  = pronto_q;
  assign ocupado = (estado_q == RECEBENDO);
`ifdef PARIDADE_PLACAR_EN
  assign erro_paridade = erro_q;
`else
  assign erro_paridade = 1'b0;
`endif

endmodule
